// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline stage behind the 64-bit ALU. Each accepted instruction
//   becomes exactly one write-back record. Loads and stores first run one
//   data-memory transaction over a req/ack handshake, and upstream is
//   stalled while it is outstanding. Misaligned addresses, illegal
//   read+write control and a bus-response timeout become exception codes.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready EX handshake (in_ready is registered)
//   flush             drop the instruction offered this cycle
//   alu_result        ALU result / memory byte address
//   alu_overflow      ALU overflow, carried through to wb_overflow
//   store_data        store data (rs2)
//   rd, mem_read, mem_write, reg_write, mem_to_reg   control bits
//   dmem_req/we/addr/wdata, dmem_ack/rdata          data-memory bus
//   wb_valid, wb_rd, wb_data, wb_reg_write, wb_overflow, wb_exc  WB record
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [63:0]       alu_result,
   input  logic              alu_overflow,
   input  logic [63:0]       store_data,
   input  logic [4:0]        rd,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [63:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [63:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [63:0]       wb_data,
   output logic              wb_reg_write,
   output logic              wb_overflow,
   output logic [1:0]        wb_exc
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_MEM_WAIT = 1'b1;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

   // Last MEM_WAIT cycle that may still complete normally; TIMEOUT is
   // limited to 2..255 so the limit fits the 8-bit counter.
   localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

   logic [0:0]  state_p1;
   logic [7:0]  tcnt_p1;

   // Fields of the outstanding memory instruction, needed at completion.
   logic [63:0] alu_p1;
   logic [4:0]  rd_p1;
   logic        reg_write_p1;
   logic        load_wb_p1;
   logic        ovf_p1;

   logic        accept;
   logic        is_access;
   logic        is_illegal;
   logic        is_misaligned;
   logic        is_mem_op;
   logic [1:0]  idle_exc;

   // in_ready is only high in IDLE, so accept never fires in MEM_WAIT and
   // flush cannot disturb an outstanding access.
   assign accept = in_valid & in_ready & ~flush;

   always_comb begin
      is_access     = mem_read | mem_write;
      is_illegal    = mem_read & mem_write;
      is_misaligned = is_access & ~is_illegal & (alu_result[2:0] != 3'b000);
      is_mem_op     = is_access & ~is_illegal & ~is_misaligned;
      idle_exc      = EXC_NONE;
      if (is_illegal)
         idle_exc = EXC_ILLEGAL;
      else if (is_misaligned)
         idle_exc = EXC_MISALIGN;
   end

   // ---- stage p0 -> p1: capture of the memory instruction ----
   always_ff @(posedge clk) begin
      if (state_p1 == S_IDLE && accept) begin
         alu_p1       <= alu_result;
         rd_p1        <= rd;
         reg_write_p1 <= reg_write;
         load_wb_p1   <= mem_read & mem_to_reg;
         ovf_p1       <= alu_overflow;
      end
   end

   // ---- stage p1 -> WB: control, memory bus and write-back record ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1     <= S_IDLE;
         in_ready     <= 1'b0;
         tcnt_p1      <= 8'd0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= 64'd0;
         wb_valid     <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= 64'd0;
         wb_reg_write <= 1'b0;
         wb_overflow  <= 1'b0;
         wb_exc       <= EXC_NONE;
      end else begin
         wb_valid <= 1'b0;
         in_ready <= (state_p1 == S_IDLE);
         case (state_p1)
            S_IDLE: begin
               if (accept) begin
                  if (is_mem_op) begin
                     state_p1   <= S_MEM_WAIT;
                     in_ready   <= 1'b0;
                     tcnt_p1    <= 8'd0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_write;
                     dmem_addr  <= alu_result[ADDR_W-1:0];
                     dmem_wdata <= store_data;
                  end else begin
                     // ALU ops and early faults retire the next cycle.
                     wb_valid     <= 1'b1;
                     wb_rd        <= rd;
                     wb_data      <= alu_result;
                     wb_overflow  <= alu_overflow;
                     wb_reg_write <= reg_write & ~is_access;
                     wb_exc       <= idle_exc;
                  end
               end
            end
            default: begin
               // An ack in the limit cycle still wins over the timeout.
               if (dmem_ack) begin
                  state_p1     <= S_IDLE;
                  in_ready     <= 1'b1;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_rd        <= rd_p1;
                  wb_data      <= load_wb_p1 ? dmem_rdata : alu_p1;
                  wb_overflow  <= ovf_p1;
                  wb_reg_write <= reg_write_p1;
                  wb_exc       <= EXC_NONE;
               end else if (tcnt_p1 == TLIM) begin
                  state_p1     <= S_IDLE;
                  in_ready     <= 1'b1;
                  dmem_req     <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_rd        <= rd_p1;
                  wb_data      <= alu_p1;
                  wb_overflow  <= ovf_p1;
                  wb_reg_write <= 1'b0;
                  wb_exc       <= EXC_TIMEOUT;
               end else begin
                  tcnt_p1 <= tcnt_p1 + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Self-checking bench for ex_mem_stage: directed scenarios followed by
//   randomized traffic, all checked every cycle against a transaction-level
//   reference model, plus literal expectations on the directed scenarios.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [63:0]       alu_result;
   logic              alu_overflow;
   logic [63:0]       store_data;
   logic [4:0]        rd;
   logic              mem_read;
   logic              mem_write;
   logic              reg_write;
   logic              mem_to_reg;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [63:0]       dmem_wdata;
   logic              dmem_ack;
   logic [63:0]       dmem_rdata;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [63:0]       wb_data;
   logic              wb_reg_write;
   logic              wb_overflow;
   logic [1:0]        wb_exc;

   ex_mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .alu_result(alu_result), .alu_overflow(alu_overflow),
      .store_data(store_data), .rd(rd),
      .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_reg_write(wb_reg_write), .wb_overflow(wb_overflow), .wb_exc(wb_exc)
   );

   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   // ---------------- reference model (transaction level) ----------------
   bit          busy;          // a memory access is outstanding
   int          req_cycles;    // request cycles seen so far for it
   logic [63:0] p_alu;
   logic [4:0]  p_rd;
   logic        p_rw, p_load_wb, p_ovf;

   logic        m_in_ready, m_req, m_we, m_wb_valid, m_wb_rw, m_wb_ovf;
   logic [31:0] m_addr;
   logic [63:0] m_wdata, m_wb_data;
   logic [4:0]  m_wb_rd;
   logic [1:0]  m_wb_exc;
   bit          m_data_dc;     // wb_data is not defined after a timeout

   task automatic model_reset();
      busy = 0; req_cycles = 0; m_data_dc = 0;
      m_in_ready = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wb_valid = 0; m_wb_rd = 0; m_wb_data = 0; m_wb_rw = 0;
      m_wb_ovf = 0; m_wb_exc = 0;
   endtask

   task automatic emit(input logic [4:0] r, input logic [63:0] d,
                       input logic rw, input logic ov, input logic [1:0] ex);
      m_wb_valid = 1; m_wb_rd = r; m_wb_data = d; m_wb_rw = rw;
      m_wb_ovf = ov; m_wb_exc = ex; m_data_dc = 0;
   endtask

   // One clock edge of the stage, computed from the rules of the block.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_wb_valid = 0;
      if (!busy) begin
         if (in_valid && !flush) begin
            if (mem_read && mem_write)
               emit(rd, alu_result, 0, alu_overflow, 2'b11);
            else if ((mem_read || mem_write) && (alu_result % 8) != 0)
               emit(rd, alu_result, 0, alu_overflow, 2'b01);
            else if (mem_read || mem_write) begin
               busy = 1; req_cycles = 0;
               m_req = 1; m_we = mem_write; m_addr = alu_result[31:0];
               m_wdata = store_data;
               p_alu = alu_result; p_rd = rd; p_rw = reg_write;
               p_load_wb = mem_read && mem_to_reg; p_ovf = alu_overflow;
            end else
               emit(rd, alu_result, reg_write, alu_overflow, 2'b00);
         end
      end else begin
         req_cycles++;
         if (dmem_ack) begin
            busy = 0; m_req = 0;
            emit(p_rd, p_load_wb ? dmem_rdata : p_alu, p_rw, p_ovf, 2'b00);
         end else if (req_cycles == TIMEOUT) begin
            busy = 0; m_req = 0;
            emit(p_rd, p_alu, 0, p_ovf, 2'b10);
            m_data_dc = 1;
         end
      end
      m_in_ready = !busy;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("in_ready",     64'(in_ready),     64'(m_in_ready));
      chk("dmem_req",     64'(dmem_req),     64'(m_req));
      chk("dmem_we",      64'(dmem_we),      64'(m_we));
      chk("dmem_addr",    64'(dmem_addr),    64'(m_addr));
      chk("dmem_wdata",   dmem_wdata,        m_wdata);
      chk("wb_valid",     64'(wb_valid),     64'(m_wb_valid));
      chk("wb_rd",        64'(wb_rd),        64'(m_wb_rd));
      if (!m_data_dc)
         chk("wb_data",   wb_data,           m_wb_data);
      chk("wb_reg_write", 64'(wb_reg_write), 64'(m_wb_rw));
      chk("wb_overflow",  64'(wb_overflow),  64'(m_wb_ovf));
      chk("wb_exc",       64'(wb_exc),       64'(m_wb_exc));
   endtask

   // Inputs are stable around the rising edge; outputs are checked on the
   // falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle_in();
      in_valid = 0; flush = 0; alu_result = 0; alu_overflow = 0;
      store_data = 0; rd = 0; mem_read = 0; mem_write = 0;
      reg_write = 0; mem_to_reg = 0;
   endtask

   task automatic offer(input logic [63:0] a, input logic [4:0] r,
                        input logic mr, input logic mw, input logic rw,
                        input logic m2r, input logic [63:0] sd);
      in_valid = 1; flush = 0; alu_result = a; alu_overflow = 0;
      store_data = sd; rd = r; mem_read = mr; mem_write = mw;
      reg_write = rw; mem_to_reg = m2r;
   endtask

   // Memory responder: acks on request cycle ack_at (0 = never) and counts
   // how many cycles dmem_req was seen high. With hammer set, EX keeps
   // offering flushed instructions throughout the wait.
   task automatic mem_run(input int ack_at, input logic [63:0] rdata,
                          input bit hammer, output int reqcnt);
      int guard;
      guard = 0; reqcnt = 0;
      while (dmem_req === 1'b1 && guard < 300) begin
         reqcnt++; guard++;
         dmem_ack   = (reqcnt == ack_at);
         dmem_rdata = dmem_ack ? rdata : {$urandom, $urandom};
         if (hammer) begin
            offer({$urandom, $urandom}, 5'($urandom), 0, 0, 1, 0, 0);
            flush = 1;
         end
         tick();
      end
      dmem_ack = 0;
      idle_in();
      if (guard >= 300) begin
         n_tests++; n_fail++;
         $display("FAIL mem_run_bound: dmem_req still high after %0d cycles, expected release", guard);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt;
      int ack_pct;
      n_tests = 0; n_fail = 0;
      rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
      idle_in();
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_wb_valid", 64'(wb_valid), 64'd0);
      rst_n = 1;
      tick();
      chk("in_ready_after_reset", 64'(in_ready), 64'd1);

      // ALU op stream, one per cycle
      offer(64'd5, 5'd1, 0, 0, 1, 0, 0); tick();
      chk("alu0_data", wb_data, 64'd5);
      offer(64'd7, 5'd2, 0, 0, 1, 0, 0); tick();
      chk("alu1_data", wb_data, 64'd7);
      chk("alu1_valid", 64'(wb_valid), 64'd1);
      offer(64'd9, 5'd3, 0, 0, 1, 0, 0); tick();
      chk("alu2_data", wb_data, 64'd9);
      chk("alu2_rd", 64'(wb_rd), 64'd3);
      chk("alu_in_ready", 64'(in_ready), 64'd1);
      chk("alu_no_req", 64'(dmem_req), 64'd0);
      idle_in(); tick();
      chk("alu_hold_data", wb_data, 64'd9);

      // Load with ack on the third request cycle
      offer(64'h100, 5'd4, 1, 0, 1, 1, 0); tick(); idle_in();
      chk("load_addr", 64'(dmem_addr), 64'h100);
      chk("load_we", 64'(dmem_we), 64'd0);
      mem_run(3, 64'hDEADBEEF, 0, cnt);
      chk("load_req_cycles", 64'(cnt), 64'd3);
      chk("load_wb_data", wb_data, 64'hDEADBEEF);
      chk("load_wb_rd", 64'(wb_rd), 64'd4);
      chk("load_wb_rw", 64'(wb_reg_write), 64'd1);

      // Store acked in the first request cycle, then a misaligned load
      offer(64'h108, 5'd5, 0, 1, 0, 0, 64'h55); tick(); idle_in();
      chk("store_we", 64'(dmem_we), 64'd1);
      chk("store_wdata", dmem_wdata, 64'h55);
      mem_run(1, 64'h0, 0, cnt);
      chk("store_req_cycles", 64'(cnt), 64'd1);
      chk("store_wb_rw", 64'(wb_reg_write), 64'd0);
      offer(64'h10C, 5'd6, 1, 0, 1, 1, 0); tick(); idle_in();
      chk("misalign_exc", 64'(wb_exc), 64'd1);
      chk("misalign_rw", 64'(wb_reg_write), 64'd0);
      chk("misalign_no_req", 64'(dmem_req), 64'd0);

      // Timeout, then an ack exactly on the limit cycle
      offer(64'h200, 5'd7, 1, 0, 1, 1, 0); tick(); idle_in();
      mem_run(0, 64'h0, 0, cnt);
      chk("timeout_req_cycles", 64'(cnt), 64'd16);
      chk("timeout_exc", 64'(wb_exc), 64'd2);
      chk("timeout_rw", 64'(wb_reg_write), 64'd0);
      chk("timeout_in_ready", 64'(in_ready), 64'd1);
      offer(64'h208, 5'd8, 1, 0, 1, 1, 0); tick(); idle_in();
      mem_run(16, 64'h1234, 0, cnt);
      chk("late_ack_req_cycles", 64'(cnt), 64'd16);
      chk("late_ack_exc", 64'(wb_exc), 64'd0);
      chk("late_ack_data", wb_data, 64'h1234);

      // Illegal control, flush while idle, flush during a wait
      offer(64'h300, 5'd9, 1, 1, 1, 0, 0); tick(); idle_in();
      chk("illegal_exc", 64'(wb_exc), 64'd3);
      chk("illegal_no_req", 64'(dmem_req), 64'd0);
      offer(64'h400, 5'd10, 0, 0, 1, 0, 0); flush = 1; tick(); idle_in();
      chk("flush_no_wb", 64'(wb_valid), 64'd0);
      offer(64'h500, 5'd11, 1, 0, 1, 1, 0); tick(); idle_in();
      mem_run(2, 64'hCAFE, 1, cnt);
      chk("flush_wait_valid", 64'(wb_valid), 64'd1);
      chk("flush_wait_data", wb_data, 64'hCAFE);

      // Reset in the middle of an access; a stale ack afterwards is ignored
      offer(64'h600, 5'd12, 1, 0, 1, 1, 0); tick(); idle_in();
      chk("midrst_req_before", 64'(dmem_req), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("midrst_req", 64'(dmem_req), 64'd0);
      chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      tick();
      rst_n = 1;
      dmem_ack = 1; dmem_rdata = 64'hBAD;
      tick();
      dmem_ack = 0;
      chk("postrst_in_ready", 64'(in_ready), 64'd1);
      chk("stale_ack_no_wb", 64'(wb_valid), 64'd0);

      // Randomized traffic: mostly-responsive memory, then a sluggish one
      for (int i = 0; i < 900; i++) begin
         ack_pct = (i < 600) ? 35 : 4;
         in_valid     = ($urandom_range(99) < 70);
         flush        = ($urandom_range(99) < 10);
         alu_result   = {$urandom, $urandom};
         if ($urandom_range(99) < 80) alu_result[2:0] = 3'b000;
         alu_overflow = 1'($urandom);
         store_data   = {$urandom, $urandom};
         rd           = 5'($urandom);
         mem_read     = ($urandom_range(99) < 35);
         mem_write    = ($urandom_range(99) < 30);
         reg_write    = 1'($urandom);
         mem_to_reg   = 1'($urandom);
         dmem_ack     = ($urandom_range(99) < ack_pct);
         dmem_rdata   = {$urandom, $urandom};
         tick();
      end
      idle_in(); dmem_ack = 0;
      repeat (TIMEOUT + 2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
